// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
//   Ping-pong reorder buffer that follows the last R2SDF stage of the
//   pipelined FFT. It collects one frame of N = 2^LOG2_POINTS complex samples
//   that arrive in bit-reversed order. It then streams the frame out in
//   natural order over a valid/ready handshake. When rev_en is low at the
//   start of a frame, the frame is stored as-is. A frame that arrives while
//   both banks hold unread data is dropped, and the sticky ovf flag is set.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rev_en            1: frame is bit-reversed (sampled on the frame's first sample)
//   di_en/di_re/di_im input sample strobe and data (gaps allowed)
//   do_ready          downstream ready
//   do_valid          output sample valid
//   do_re/do_im       output data, natural order
//   do_idx            natural-order bin index of the current output
//   do_last           high with bin N-1
//   ovf, ovf_clr      sticky dropped-frame flag and its clear
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH  = 16,
  parameter int LOG2_POINTS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rev_en,
  input  logic                   di_en,
  input  logic [DATA_WIDTH-1:0]  di_re,
  input  logic [DATA_WIDTH-1:0]  di_im,
  input  logic                   do_ready,
  output logic                   do_valid,
  output logic [DATA_WIDTH-1:0]  do_re,
  output logic [DATA_WIDTH-1:0]  do_im,
  output logic [LOG2_POINTS-1:0] do_idx,
  output logic                   do_last,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int N = 1 << LOG2_POINTS;
  localparam logic [LOG2_POINTS-1:0] CNT_LAST = '1;

  typedef enum logic {S_IDLE, S_READ} state_t;

  function automatic logic [LOG2_POINTS-1:0] bitrev(input logic [LOG2_POINTS-1:0] a);
    logic [LOG2_POINTS-1:0] r;
    for (int i = 0; i < LOG2_POINTS; i++) r[i] = a[LOG2_POINTS-1-i];
    return r;
  endfunction

  logic [DATA_WIDTH-1:0]  mem_re [2][N];
  logic [DATA_WIDTH-1:0]  mem_im [2][N];

  logic [1:0]             full, full_set, full_clr;
  logic                   wr_bank, rd_bank, rd_other;
  logic                   drop, rev_q, ovf_q;
  logic [LOG2_POINTS-1:0] wr_cnt, rd_cnt, wr_addr;
  logic                   frame_start, bank_free, drop_now, rev_now, wr_last;
  logic                   rd_xfer, rd_done;
  state_t                 state, state_nxt;

  // Write-side decode: frame start, bank availability with read forwarding.
  always_comb begin
    rd_other    = ~rd_bank;
    rd_xfer     = (state == S_READ) && do_ready;
    rd_done     = rd_xfer && (rd_cnt == CNT_LAST);
    frame_start = di_en && (wr_cnt == '0);
    wr_last     = di_en && (wr_cnt == CNT_LAST);
    // A bank whose last sample is read out on this edge can be refilled
    // starting on the same edge.
    bank_free   = !full[wr_bank] || (rd_done && (rd_bank == wr_bank));
    drop_now    = frame_start ? !bank_free : drop;
    rev_now     = frame_start ? rev_en : rev_q;
    wr_addr     = rev_now ? bitrev(wr_cnt) : wr_cnt;
    full_set    = '0;
    full_clr    = '0;
    if (wr_last && !drop_now) full_set[wr_bank] = 1'b1;
    if (rd_done)              full_clr[rd_bank] = 1'b1;
  end

  // Bank storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (di_en && !drop_now) begin
      mem_re[wr_bank][wr_addr] <= di_re;
      mem_im[wr_bank][wr_addr] <= di_im;
    end
  end

  // Write-side control, bank full flags, overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      drop    <= 1'b0;
      rev_q   <= 1'b0;
      full    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (di_en) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (frame_start) rev_q <= rev_en;
        if (wr_last) begin
          drop <= 1'b0;
          if (!drop_now) wr_bank <= ~wr_bank;
        end else begin
          drop <= drop_now;
        end
      end
      full <= (full & ~full_clr) | full_set;
      if (frame_start && !bank_free) ovf_q <= 1'b1;
      else if (ovf_clr)              ovf_q <= 1'b0;
    end
  end

  // Read FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Read FSM: next state. A bank completed on this edge counts as full. As a
  // result, do_valid rises on the cycle right after the final write, and
  // back-to-back frames drain without a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (full[rd_bank] || full_set[rd_bank]) state_nxt = S_READ;
      S_READ: if (rd_done)
                state_nxt = (full[rd_other] || full_set[rd_other]) ? S_READ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_xfer) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  // Read FSM: outputs. Data is forced to zero when nothing is presented.
  always_comb begin
    do_valid = (state == S_READ);
    do_last  = do_valid && (rd_cnt == CNT_LAST);
    do_idx   = rd_cnt;
    do_re    = do_valid ? mem_re[rd_bank][rd_cnt] : '0;
    do_im    = do_valid ? mem_im[rd_bank][rd_cnt] : '0;
    ovf      = ovf_q;
  end

endmodule
